uart_rx: RTL



---
 rtl/uart_rx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver driven by a 16x baud tick enable.
// Oversamples a synchronized rx line, validates the start bit at mid-bit,
// samples each data bit 16 ticks after the previous one, and hands the
// byte to the register block through a data_ready/read handshake with
// sticky overrun and framing-error flags.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | line idle, waiting for a low sample to begin a start bit
// S_START     | counting to mid start bit to reject glitches
// S_DATA      | sampling 8 data bits, LSB first, every 16 ticks
// S_STOP      | sampling the stop bit, then deliver or flag framing error
// S_WAIT_IDLE | stop bit was low (break); wait for the line to go high
module uart_rx (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_tick_16x,
  input  logic       rx,
  input  logic       read,
  output logic [7:0] data,
  output logic       data_ready,
  output logic       overrun,
  output logic       frame_error
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_meta_d;
  logic        rx_sync_q, rx_sync_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        data_ready_q, data_ready_d;
  logic        overrun_q, overrun_d;
  logic        frame_error_q, frame_error_d;

  // Strobes from the frame FSM to the output register.
  logic        deliver;
  logic        stop_bad;

  // Two-flop synchronizer input; idle-high line.
  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
  end

  // Frame FSM: every change is gated by the 16x tick.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    deliver    = 1'b0;
    stop_bad   = 1'b0;
    if (uart_tick_16x) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_sync_q) begin
            state_d    = S_START;
            tick_cnt_d = 4'd0;
          end
        end
        S_START: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd7) begin
            if (!rx_sync_q) begin
              state_d    = S_DATA;
              tick_cnt_d = 4'd0;
              bit_idx_d  = 3'd0;
            end else begin
              state_d    = S_IDLE;
              tick_cnt_d = 4'd0;
            end
          end
        end
        S_DATA: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_d   = {rx_sync_q, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_d = S_STOP;
            end
          end
        end
        S_STOP: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            if (rx_sync_q) begin
              deliver = 1'b1;
              state_d = S_IDLE;
            end else begin
              stop_bad = 1'b1;
              state_d  = S_WAIT_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (rx_sync_q) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d    = S_IDLE;
          tick_cnt_d = 4'd0;
          bit_idx_d  = 3'd0;
        end
      endcase
    end
  end

  // Output register and sticky flags; a new event in the same cycle as read wins.
  always_comb begin
    data_d        = data_q;
    data_ready_d  = data_ready_q;
    overrun_d     = overrun_q;
    frame_error_d = frame_error_q;
    if (read) begin
      data_ready_d  = 1'b0;
      overrun_d     = 1'b0;
      frame_error_d = 1'b0;
    end
    if (deliver) begin
      if (!data_ready_q || read) begin
        data_d       = shift_q;
        data_ready_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (stop_bad) begin
      frame_error_d = 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      state_q       <= S_IDLE;
      tick_cnt_q    <= 4'd0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      data_q        <= 8'h00;
      data_ready_q  <= 1'b0;
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      rx_meta_q     <= rx_meta_d;
      rx_sync_q     <= rx_sync_d;
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      data_ready_q  <= data_ready_d;
      overrun_q     <= overrun_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign data        = data_q;
  assign data_ready  = data_ready_q;
  assign overrun     = overrun_q;
  assign frame_error = frame_error_q;

endmodule
